ahb_sram_slave: RTL and testbench
=================================

# ahb_sram_slave

AHB-Lite slave backed by an on-chip word SRAM. It sits directly downstream of `master_ahb` on the shared HADDR/HWDATA/HTRANS bus. It accepts SINGLE, INCR4 and WRAP4 bursts of byte, halfword or word size. The block inserts a programmable number of wait states per data phase, returns read data, and issues the standard two-cycle ERROR response for illegal accesses.

## Interface
Parameters:
- `ADDR_W`, 10: byte-address bits decoded. Memory depth is 2^(ADDR_W-2) 32-bit words.
- `WAIT_STATES`, 0: wait cycles inserted per data phase. Legal range 0..3.

Ports:
- `HCLK` in 1: single clock. All state changes on the rising edge.
- `HRESETn` in 1: reset, asynchronous, active-low.
- `HSEL` in 1: slave select from the decoder.
- `HADDR` in 32: byte address.
- `HWRITE` in 1: 1 = write, 0 = read.
- `HSIZE` in 3: 0 = byte, 1 = halfword, 2 = word.
- `HBURST` in 3: burst type. Sampled only; it has no effect on behaviour.
- `HTRANS` in 2: IDLE = 00, BUSY = 01, NONSEQ = 10, SEQ = 11.
- `HWDATA` in 32: write data, valid in the data phase.
- `HREADY` in 1: bus-level ready (the mux output), used to qualify the address phase.
- `HREADYOUT` out 1: this slave's ready.
- `HRESP` out 1: 0 = OKAY, 1 = ERROR.
- `HRDATA` out 32: read data.

## Operation
Address-phase acceptance:
- An address phase is accepted when `HSEL && HREADY && HTRANS[1]` at a rising edge.
- On acceptance the block registers the address, write flag, size and an error flag.
- IDLE, BUSY or unselected transfers are not accepted. They get a zero-wait OKAY and have no side effects.

Error conditions (the flag is set if any of these holds):
- `HADDR[31:ADDR_W] != 0`.
- `HSIZE > 2`.
- Halfword access with `HADDR[0] = 1`.
- Word access with `HADDR[1:0] != 0`.

State machine:
- States: DS_IDLE, DS_WAIT, DS_LAST, DS_ERR1, DS_ERR2.

Transitions on acceptance:
- Error flag set → DS_ERR1.
- Otherwise, `WAIT_STATES > 0` → DS_WAIT, with the wait counter loaded to `WAIT_STATES-1`.
- Otherwise → DS_LAST.

Per-state behaviour:
- **DS_WAIT:** `HREADYOUT = 0`. The counter decrements each cycle; at 0 the FSM goes to DS_LAST.
- **DS_LAST:** `HREADYOUT = 1`, `HRESP = 0`. The transfer completes at this edge. A new accepted address phase at the same edge re-enters as above; otherwise the FSM goes to DS_IDLE.
- **DS_ERR1:** `HREADYOUT = 0`, `HRESP = 1`. Always goes to DS_ERR2.
- **DS_ERR2:** `HREADYOUT = 1`, `HRESP = 1`. Acceptance at this edge is handled as from DS_LAST.
- **DS_IDLE:** `HREADYOUT = 1`, `HRESP = 0`.

Data transfer:
- Writes commit at the completing edge of DS_LAST, using byte enables derived from the registered size and address:
  - byte: lane `addr[1:0]`;
  - halfword: lanes `{addr[1],0}` and `{addr[1],1}`;
  - word: all four lanes.
- Byte order is little-endian.
- Reads: `HRDATA` = full word at the registered word address, driven throughout DS_WAIT and DS_LAST. It is 0 in every other state.
- Errored transfers never write memory. `HRDATA` is 0 during DS_ERR1 and DS_ERR2.

## Timing
- Reset values: `HREADYOUT = 1`, `HRESP = 0`, `HRDATA = 0`, FSM in DS_IDLE, wait counter 0. Memory contents are not reset.
- Reset mid-operation: the outputs take their reset values immediately (asynchronously). A pending write is dropped.
- Latency: data-phase length is `1 + WAIT_STATES` cycles. Errors always take 2 cycles.
- Pipelining: address phase N+1 overlaps data phase N. The block sustains one transfer every `1 + WAIT_STATES` cycles with no dead cycle.
- Write-then-read to the same word in consecutive transfers: the read data phase returns the newly written value. The write commits at the edge that begins the read's data phase.
- A WRAP4 or INCR4 burst needs no special handling. Each beat is an independent accepted transfer at the master-supplied address.
- Address phases seen while `HREADY = 0` are ignored. The master holds them until `HREADY` is high.

## Structure
Shared package `ahb_pkg`:
- `htrans_t`, `hsize_t` and `hburst_t` enums.
- `HRESP_OKAY` and `HRESP_ERROR` constants.
- Also used by `master_ahb`.

Sub-module `sram_bw`:
- Single-port RAM with 4-bit byte-write enable.
- Parameter `DEPTH`.
- Combinational read.
- Instantiated once.

The FSM, wait counter and error/byte-enable decode live in `ahb_sram_slave`.

## Test plan
1. **Single word write and read** (WAIT_STATES=0): write 0xDEADBEEF to 0x010, then read 0x010 → `HRDATA` 0xDEADBEEF with `HREADYOUT = 1` and `HRESP = 0` in the single-cycle data phase.
2. **INCR4 with wait states** (WAIT_STATES=2): write 0x11, 0x22, 0x33, 0x44 to 0x020–0x02C → each beat shows `HREADYOUT` low 2 cycles then high 1 cycle. WRAP4 read from 0x028 → returns 0x33, 0x44, 0x11, 0x22.
3. **Byte and halfword lanes**: word 0x030 = 0; byte write 0xAB at 0x031 → reads 0x0000AB00. Halfword write 0x1234 at 0x032 → reads 0x1234AB00.
4. **Error responses**: word write at 0x0000_1000 (ADDR_W=10) → `HREADYOUT` 0 then 1 with `HRESP = 1` both cycles. Same response for a word write at 0x002 and for HSIZE = 3. Memory is unchanged in all three cases.
5. **Back-to-back write then read**: write 0xCAFEF00D to 0x040, immediately followed by a read of 0x040 → read returns 0xCAFEF00D. An IDLE/BUSY with `HSEL = 1` → OKAY, zero wait.
6. **Reset mid-transfer**: drop `HRESETn` during DS_WAIT of a write of 0x55 to 0x050 → `HREADYOUT = 1` and `HRESP = 0` immediately. After release, a read of 0x050 returns its pre-write value.

Source files
------------

// File: rtl/ahb_pkg.sv
// Shared AHB-Lite bus definitions used by the slave and master blocks.
// Also holds the slave data-phase state type and byte-lane decode helper.
package ahb_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_t;

  typedef enum logic [2:0] {
    HSIZE_BYTE = 3'd0,
    HSIZE_HALF = 3'd1,
    HSIZE_WORD = 3'd2
  } hsize_t;

  typedef enum logic [2:0] {
    HBURST_SINGLE = 3'd0,
    HBURST_INCR   = 3'd1,
    HBURST_WRAP4  = 3'd2,
    HBURST_INCR4  = 3'd3,
    HBURST_WRAP8  = 3'd4,
    HBURST_INCR8  = 3'd5,
    HBURST_WRAP16 = 3'd6,
    HBURST_INCR16 = 3'd7
  } hburst_t;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [2:0] {
    DS_IDLE,
    DS_WAIT,
    DS_LAST,
    DS_ERR1,
    DS_ERR2
  } ds_state_t;

  // Little-endian lane enables for a legal (already checked) size/offset pair.
  function automatic logic [3:0] byte_en(input logic [1:0] size, input logic [1:0] offs);
    case (size)
      2'd0:    return 4'b0001 << offs;
      2'd1:    return offs[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/sram_bw.sv
// Single-port word RAM with per-byte write enables and combinational read.
module sram_bw #(
  parameter int DEPTH = 256
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [3:0]               be,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic [31:0]              wdata,
  output logic [31:0]              rdata
);

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/ahb_sram_slave.sv
// AHB-Lite SRAM slave: registers the address phase, inserts WAIT_STATES wait
// cycles per data phase and answers illegal accesses with a two-cycle ERROR.
module ahb_sram_slave
  import ahb_pkg::*;
#(
  parameter int ADDR_W      = 10,
  parameter int WAIT_STATES = 0
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic        HWRITE,
  input  logic [2:0]  HSIZE,
  input  logic [2:0]  HBURST,
  input  logic [1:0]  HTRANS,
  input  logic [31:0] HWDATA,
  input  logic        HREADY,
  output logic        HREADYOUT,
  output logic        HRESP,
  output logic [31:0] HRDATA
);

  localparam int         DEPTH   = 1 << (ADDR_W - 2);
  localparam logic [1:0] WS_LOAD = 2'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

  ds_state_t          state_q, state_d;
  logic [1:0]         cnt_q, cnt_d;
  logic [ADDR_W-1:0]  addr_q;
  logic               write_q;
  logic [1:0]         size_q;
  logic               take;
  logic               addr_err;
  logic               mem_we;
  logic [31:0]        mem_rdata;
  logic               unused_hburst;

  // Handshake: an address phase is valid when HSEL && HTRANS[1]; it is taken
  // only on an edge where the bus HREADY is high, and a data phase completes
  // on the edge where HREADYOUT is high. The master holds everything otherwise.
  assign take = HSEL && HREADY && HTRANS[1] &&
                (state_q == DS_IDLE || state_q == DS_LAST || state_q == DS_ERR2);

  assign addr_err = (|HADDR[31:ADDR_W]) ||
                    (HSIZE > 3'd2) ||
                    ((HSIZE == 3'd1) && HADDR[0]) ||
                    ((HSIZE == 3'd2) && (HADDR[1:0] != 2'b00));

  // Burst type carries no meaning here: every beat arrives with its own address.
  assign unused_hburst = ^HBURST;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    HREADYOUT = 1'b1;
    HRESP     = HRESP_OKAY;
    HRDATA    = 32'h0;

    case (state_q)
      DS_WAIT: begin
        HREADYOUT = 1'b0;
        if (!write_q) HRDATA = mem_rdata;
        if (cnt_q == 2'd0) state_d = DS_LAST;
        else               cnt_d   = cnt_q - 2'd1;
      end
      DS_LAST: begin
        if (!write_q) HRDATA = mem_rdata;
        state_d = DS_IDLE;
      end
      DS_ERR1: begin
        HREADYOUT = 1'b0;
        HRESP     = HRESP_ERROR;
        state_d   = DS_ERR2;
      end
      DS_ERR2: begin
        HRESP   = HRESP_ERROR;
        state_d = DS_IDLE;
      end
      default: state_d = DS_IDLE;
    endcase

    if (take) begin
      if (addr_err) begin
        state_d = DS_ERR1;
      end else if (WAIT_STATES > 0) begin
        state_d = DS_WAIT;
        cnt_d   = WS_LOAD;
      end else begin
        state_d = DS_LAST;
      end
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q <= DS_IDLE;
      cnt_q   <= 2'd0;
      addr_q  <= '0;
      write_q <= 1'b0;
      size_q  <= 2'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (take) begin
        addr_q  <= HADDR[ADDR_W-1:0];
        write_q <= HWRITE;
        size_q  <= HSIZE[1:0];
      end
    end
  end

  // DS_LAST is only reachable for error-free transfers, so errors never write.
  assign mem_we = (state_q == DS_LAST) && write_q;

  sram_bw #(
    .DEPTH (DEPTH)
  ) u_ram (
    .clk   (HCLK),
    .we    (mem_we),
    .be    (byte_en(size_q, addr_q[1:0])),
    .addr  (addr_q[ADDR_W-1:2]),
    .wdata (HWDATA),
    .rdata (mem_rdata)
  );

endmodule

// File: tb/tb_ahb_sram_slave.sv
// Bench for ahb_sram_slave: two slaves (0 and 2 wait states) on one bus,
// driven from a vector table plus hand-written pipelined and reset sequences.
module tb_ahb_sram_slave;
  import ahb_pkg::*;

  typedef struct {
    bit          tgt;
    bit          wr;
    logic [1:0]  trans;
    logic [2:0]  burst;
    logic [2:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    int          waits;
    bit          err;
  } vec_t;

  logic        HCLK;
  logic        HRESETn;
  logic        sel0, sel2;
  logic [31:0] HADDR;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [2:0]  HBURST;
  logic [1:0]  HTRANS;
  logic [31:0] HWDATA;
  logic        hready;
  logic        ready0, resp0, ready2, resp2;
  logic [31:0] rdata0, rdata2;
  logic        bus_ready, bus_resp;
  logic [31:0] bus_rdata;

  int n_checks = 0;
  int n_err    = 0;
  vec_t vecs[$];

  assign hready    = sel2 ? ready2 : (sel0 ? ready0 : 1'b1);
  assign bus_ready = hready;
  assign bus_resp  = sel2 ? resp2  : (sel0 ? resp0  : 1'b0);
  assign bus_rdata = sel2 ? rdata2 : (sel0 ? rdata0 : 32'h0);

  ahb_sram_slave #(.ADDR_W(10), .WAIT_STATES(0)) u0 (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(sel0), .HADDR(HADDR), .HWRITE(HWRITE),
    .HSIZE(HSIZE), .HBURST(HBURST), .HTRANS(HTRANS), .HWDATA(HWDATA),
    .HREADY(hready), .HREADYOUT(ready0), .HRESP(resp0), .HRDATA(rdata0)
  );

  ahb_sram_slave #(.ADDR_W(10), .WAIT_STATES(2)) u2 (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(sel2), .HADDR(HADDR), .HWRITE(HWRITE),
    .HSIZE(HSIZE), .HBURST(HBURST), .HTRANS(HTRANS), .HWDATA(HWDATA),
    .HREADY(hready), .HREADYOUT(ready2), .HRESP(resp2), .HRDATA(rdata2)
  );

  // clock / reset
  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add(input bit tgt, input bit wr, input logic [1:0] trans,
                     input logic [2:0] burst, input logic [2:0] size,
                     input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [31:0] exp_rd, input int waits, input bit err);
    vec_t v;
    v.tgt = tgt; v.wr = wr; v.trans = trans; v.burst = burst; v.size = size;
    v.addr = addr; v.wdata = wdata; v.exp_rd = exp_rd; v.waits = waits; v.err = err;
    vecs.push_back(v);
  endtask

  // Called at posedge+1 right after an address phase was presented/accepted.
  task automatic data_phase(input string name, input bit chk_rd, input logic [31:0] exp_rd,
                            input int exp_waits, input bit exp_err);
    int waits;
    bit done;
    waits = 0;
    done  = 1'b0;
    for (int c = 0; c < 8 && !done; c++) begin
      @(negedge HCLK);
      chk($sformatf("%s resp", name), 32'(bus_resp), 32'(exp_err));
      if (exp_err) chk($sformatf("%s err_rdata", name), bus_rdata, 32'h0);
      if (bus_ready) begin
        done = 1'b1;
        chk($sformatf("%s waits", name), waits, exp_waits);
        if (chk_rd) chk($sformatf("%s rdata", name), bus_rdata, exp_rd);
      end else begin
        waits++;
      end
      @(posedge HCLK); #1;
    end
    if (!done) chk($sformatf("%s timeout", name), 32'd0, 32'd1);
  endtask

  task automatic xfer(input vec_t v, input string name);
    sel0   = !v.tgt;
    sel2   = v.tgt;
    HADDR  = v.addr;
    HWRITE = v.wr;
    HSIZE  = v.size;
    HBURST = v.burst;
    HTRANS = v.trans;
    @(posedge HCLK); #1;
    HTRANS = HTRANS_IDLE;
    HWDATA = v.wdata;
    data_phase(name, !v.wr && !v.err, v.exp_rd, v.waits, v.err);
  endtask

  task automatic rd(input bit tgt, input logic [31:0] addr, input logic [31:0] exp, input int waits,
                    input string name);
    vec_t v;
    v.tgt = tgt; v.wr = 1'b0; v.trans = HTRANS_NONSEQ; v.burst = HBURST_SINGLE;
    v.size = HSIZE_WORD; v.addr = addr; v.wdata = 32'h0; v.exp_rd = exp;
    v.waits = waits; v.err = 1'b0;
    xfer(v, name);
  endtask

  initial begin
    HRESETn = 1'b0;
    sel0 = 1'b0; sel2 = 1'b0;
    HADDR = 32'h0; HWRITE = 1'b0; HSIZE = 3'd2; HBURST = 3'd0;
    HTRANS = HTRANS_IDLE; HWDATA = 32'h0;

    // reset state
    #2;
    chk("rst ready0", 32'(ready0), 32'd1);
    chk("rst resp0",  32'(resp0),  32'd0);
    chk("rst rdata0", rdata0,      32'h0);
    chk("rst ready2", 32'(ready2), 32'd1);
    chk("rst resp2",  32'(resp2),  32'd0);
    chk("rst rdata2", rdata2,      32'h0);
    repeat (2) @(posedge HCLK);
    #1 HRESETn = 1'b1;
    @(posedge HCLK); #1;

    // tgt wr trans burst size addr wdata exp_rd waits err
    add(0, 1, HTRANS_NONSEQ, HBURST_SINGLE, HSIZE_WORD, 32'h010, 32'hDEADBEEF, 32'h0, 0, 0);
    add(0, 0, HTRANS_NONSEQ, HBURST_SINGLE, HSIZE_WORD, 32'h010, 32'h0, 32'hDEADBEEF, 0, 0);
    add(1, 1, HTRANS_NONSEQ, HBURST_INCR4, HSIZE_WORD, 32'h020, 32'h11, 32'h0, 2, 0);
    add(1, 1, HTRANS_SEQ,    HBURST_INCR4, HSIZE_WORD, 32'h024, 32'h22, 32'h0, 2, 0);
    add(1, 1, HTRANS_SEQ,    HBURST_INCR4, HSIZE_WORD, 32'h028, 32'h33, 32'h0, 2, 0);
    add(1, 1, HTRANS_SEQ,    HBURST_INCR4, HSIZE_WORD, 32'h02C, 32'h44, 32'h0, 2, 0);
    add(1, 0, HTRANS_NONSEQ, HBURST_WRAP4, HSIZE_WORD, 32'h028, 32'h0, 32'h33, 2, 0);
    add(1, 0, HTRANS_SEQ,    HBURST_WRAP4, HSIZE_WORD, 32'h02C, 32'h0, 32'h44, 2, 0);
    add(1, 0, HTRANS_SEQ,    HBURST_WRAP4, HSIZE_WORD, 32'h020, 32'h0, 32'h11, 2, 0);
    add(1, 0, HTRANS_SEQ,    HBURST_WRAP4, HSIZE_WORD, 32'h024, 32'h0, 32'h22, 2, 0);
    add(1, 1, HTRANS_NONSEQ, HBURST_SINGLE, HSIZE_WORD, 32'h030, 32'h0, 32'h0, 2, 0);
    add(1, 1, HTRANS_NONSEQ, HBURST_SINGLE, HSIZE_BYTE, 32'h031, 32'h0000AB00, 32'h0, 2, 0);
    add(1, 0, HTRANS_NONSEQ, HBURST_SINGLE, HSIZE_WORD, 32'h030, 32'h0, 32'h0000AB00, 2, 0);
    add(1, 1, HTRANS_NONSEQ, HBURST_SINGLE, HSIZE_HALF, 32'h032, 32'h12340000, 32'h0, 2, 0);
    add(1, 0, HTRANS_NONSEQ, HBURST_SINGLE, HSIZE_WORD, 32'h030, 32'h0, 32'h1234AB00, 2, 0);
    add(0, 1, HTRANS_NONSEQ, HBURST_SINGLE, HSIZE_WORD, 32'h000, 32'hA5A5A5A5, 32'h0, 0, 0);
    add(0, 1, HTRANS_NONSEQ, HBURST_SINGLE, HSIZE_WORD, 32'h1000, 32'hFFFFFFFF, 32'h0, 1, 1);
    add(0, 1, HTRANS_NONSEQ, HBURST_SINGLE, HSIZE_WORD, 32'h002, 32'hFFFFFFFF, 32'h0, 1, 1);
    add(0, 1, HTRANS_NONSEQ, HBURST_SINGLE, 3'd3,       32'h000, 32'hFFFFFFFF, 32'h0, 1, 1);
    add(0, 1, HTRANS_NONSEQ, HBURST_SINGLE, HSIZE_HALF, 32'h001, 32'hFFFFFFFF, 32'h0, 1, 1);
    add(0, 0, HTRANS_NONSEQ, HBURST_SINGLE, HSIZE_WORD, 32'h000, 32'h0, 32'hA5A5A5A5, 0, 0);
    add(1, 1, HTRANS_NONSEQ, HBURST_SINGLE, HSIZE_WORD, 32'h1020, 32'hFFFFFFFF, 32'h0, 1, 1);
    add(1, 0, HTRANS_NONSEQ, HBURST_SINGLE, HSIZE_WORD, 32'h020, 32'h0, 32'h11, 2, 0);
    add(0, 1, HTRANS_NONSEQ, HBURST_SINGLE, HSIZE_WORD, 32'h3FC, 32'h89ABCDEF, 32'h0, 0, 0);
    add(0, 0, HTRANS_NONSEQ, HBURST_SINGLE, HSIZE_BYTE, 32'h3FF, 32'h0, 32'h89ABCDEF, 0, 0);

    foreach (vecs[i]) xfer(vecs[i], $sformatf("vec%0d", i));

    // back-to-back write then read, zero wait states
    sel0 = 1'b1; sel2 = 1'b0;
    HADDR = 32'h040; HWRITE = 1'b1; HSIZE = HSIZE_WORD; HTRANS = HTRANS_NONSEQ;
    @(posedge HCLK); #1;
    HWDATA = 32'hCAFEF00D; HWRITE = 1'b0;
    data_phase("b2b0 wr", 1'b0, 32'h0, 0, 1'b0);
    HTRANS = HTRANS_IDLE;
    data_phase("b2b0 rd", 1'b1, 32'hCAFEF00D, 0, 1'b0);

    // same with wait states: the held read address must wait for HREADY
    sel0 = 1'b0; sel2 = 1'b1;
    HADDR = 32'h048; HWRITE = 1'b1; HTRANS = HTRANS_NONSEQ;
    @(posedge HCLK); #1;
    HWDATA = 32'h00000077; HWRITE = 1'b0;
    data_phase("b2b2 wr", 1'b0, 32'h0, 2, 1'b0);
    HTRANS = HTRANS_IDLE;
    data_phase("b2b2 rd", 1'b1, 32'h00000077, 2, 1'b0);

    // IDLE and BUSY while selected: zero-wait OKAY, no memory effect
    HADDR = 32'h020; HWRITE = 1'b1; HWDATA = 32'hFFFFFFFF;
    for (int k = 0; k < 2; k++) begin
      HTRANS = (k == 0) ? HTRANS_BUSY : HTRANS_IDLE;
      @(posedge HCLK); #1;
      @(negedge HCLK);
      chk($sformatf("nontrans%0d ready", k), 32'(ready2), 32'd1);
      chk($sformatf("nontrans%0d resp", k),  32'(resp2),  32'd0);
      @(posedge HCLK); #1;
    end
    HTRANS = HTRANS_IDLE;
    rd(1'b1, 32'h020, 32'h11, 2, "nontrans mem");

    // reset during DS_WAIT of a write drops the write
    add(1, 1, HTRANS_NONSEQ, HBURST_SINGLE, HSIZE_WORD, 32'h050, 32'h12345678, 32'h0, 2, 0);
    xfer(vecs[vecs.size()-1], "rst pre");
    sel2 = 1'b1; HADDR = 32'h050; HWRITE = 1'b1; HSIZE = HSIZE_WORD; HTRANS = HTRANS_NONSEQ;
    @(posedge HCLK); #1;
    HTRANS = HTRANS_IDLE; HWDATA = 32'h00000055;
    @(negedge HCLK);
    chk("rst wait ready", 32'(ready2), 32'd0);
    #2 HRESETn = 1'b0;
    #1;
    chk("rst async ready", 32'(ready2), 32'd1);
    chk("rst async resp",  32'(resp2),  32'd0);
    chk("rst async rdata", rdata2,      32'h0);
    @(posedge HCLK); #1;
    @(posedge HCLK); #1;
    HRESETn = 1'b1;
    @(posedge HCLK); #1;
    rd(1'b1, 32'h050, 32'h12345678, 2, "rst post");

    sel0 = 1'b0; sel2 = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
